snake_move_sched: RTL and testbench

Move scheduler and direction arbiter for `snake_core`. It fixes the game speed with a programmable tick and synchronizes and prioritizes the four direction buttons. It queues up to two pending turns, rejects reversals, and issues one `Step` request per tick to the core over a request/acknowledge handshake. It replaces the edge-triggered direction latch and the HOLD-based pacing inside the core with a single clocked controller.

---
 rtl/snake_move_sched_pkg.sv | 25 ++
 rtl/snake_move_sched_if.sv | 13 +
 rtl/snake_btn_sync.sv | 25 ++
 rtl/snake_move_sched.sv | 178 +++++++++++++++++
 tb/tb_snake_move_sched.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/snake_move_sched_pkg.sv
// Direction encoding, scheduler states and helpers shared by the snake core and
// its move scheduler.
package snake_pkg;

   typedef logic [1:0] dir_t;

   localparam dir_t DirLeft  = 2'b00;
   localparam dir_t DirRight = 2'b01;
   localparam dir_t DirUp    = 2'b10;
   localparam dir_t DirDown  = 2'b11;

   typedef enum logic [2:0] {
      StIdle,
      StWaitTick,
      StIssue,
      StWaitAck,
      StFault
   } sched_state_e;

   // Opposites share the axis bit and differ in the sense bit.
   function automatic dir_t opposite(input dir_t d);
      return {d[1], ~d[0]};
   endfunction

endpackage

// File: rtl/snake_move_sched_if.sv
// Step request/acknowledge channel between the move scheduler and snake_core.
interface snake_move_sched_if;
   import snake_pkg::*;

   logic Step;
   dir_t Dir;
   logic Busy;
   logic Step_Ack;

   modport master (output Step, output Dir, output Busy, input Step_Ack);
   modport slave  (input Step, input Dir, input Busy, output Step_Ack);

endinterface

// File: rtl/snake_btn_sync.sv
// Two-flop synchronizer plus rising-edge detector for one raw button.
module snake_btn_sync (
   input  logic Clk,
   input  logic Reset,
   input  logic btn,
   output logic rise
);

   logic s1_q, s2_q, prev_q;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         s1_q   <= btn;
         s2_q   <= s1_q;
         prev_q <= s2_q;
      end
   end

   assign rise = s2_q & ~prev_q;

endmodule

// File: rtl/snake_move_sched.sv
// Move scheduler: paces moves with a length-dependent tick, arbitrates buttons
// into a two-entry turn queue and issues Step requests to the core.
module snake_move_sched
   import snake_pkg::*;
#(
   parameter int unsigned CNT_W       = 26,
   parameter int unsigned BASE_PERIOD = 25000000,
   parameter int unsigned SPEEDUP     = 1000000,
   parameter int unsigned MIN_PERIOD  = 5000000,
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Left,
   input  logic               Right,
   input  logic               Up,
   input  logic               Down,
   input  logic               Enable,
   input  logic               Restart,
   input  logic [3:0]         Length,
   snake_move_sched_if.master core,
   output logic               Fault,
   output logic [1:0]         Q_Count
);

   localparam int unsigned PW = CNT_W + 4;

   // rise index equals the direction encoding
   logic [3:0] rise;

   snake_btn_sync u_sync_left  (.Clk(Clk), .Reset(Reset), .btn(Left),  .rise(rise[0]));
   snake_btn_sync u_sync_right (.Clk(Clk), .Reset(Reset), .btn(Right), .rise(rise[1]));
   snake_btn_sync u_sync_up    (.Clk(Clk), .Reset(Reset), .btn(Up),    .rise(rise[2]));
   snake_btn_sync u_sync_down  (.Clk(Clk), .Reset(Reset), .btn(Down),  .rise(rise[3]));

   sched_state_e     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d;
   logic             step_q, step_d, busy_q, busy_d, fault_q, fault_d;
   dir_t             dir_q, dir_d;
   dir_t [1:0]       q_q, q_d;
   logic [1:0]       count_q, count_d, count_pop;
   logic             pop, cand_vld, accept;
   dir_t             cand, head_pop, dir_pop, ref_dir;
   logic [PW-1:0]    prod, diff, tick_period;

   always_comb begin
      cand_vld = ~Restart;
      cand     = DirLeft;
      if      (rise[0]) cand = DirLeft;
      else if (rise[1]) cand = DirRight;
      else if (rise[2]) cand = DirUp;
      else if (rise[3]) cand = DirDown;
      else              cand_vld = 1'b0;
   end

   always_comb begin
      prod        = PW'(Length) * PW'(SPEEDUP);
      diff        = PW'(BASE_PERIOD) - prod;
      tick_period = (prod > PW'(BASE_PERIOD) || diff < PW'(MIN_PERIOD)) ? PW'(MIN_PERIOD) : diff;
   end

   // The pop is taken on the edge into ISSUE so Dir and Step rise together.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      step_d   = 1'b0;
      busy_d   = busy_q;
      fault_d  = fault_q;
      pop      = 1'b0;
      case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (Enable) begin
               state_d  = StWaitTick;
               period_d = CNT_W'(tick_period);
            end
         end
         StWaitTick: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (!Enable) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (cnt_q == period_q - CNT_W'(1)) begin
               state_d = StIssue;
               cnt_d   = '0;
               step_d  = 1'b1;
               busy_d  = 1'b1;
               pop     = (count_q != 2'd0);
            end
         end
         StIssue: begin
            state_d = StWaitAck;
            cnt_d   = cnt_q + CNT_W'(1);
         end
         StWaitAck: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (core.Step_Ack) begin
               busy_d = 1'b0;
               cnt_d  = '0;
               if (Enable) begin
                  state_d  = StWaitTick;
                  period_d = CNT_W'(tick_period);
               end else begin
                  state_d = StIdle;
               end
            end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
               state_d = StFault;
               fault_d = 1'b1;
            end
         end
         StFault: state_d = StFault;
         default: state_d = StIdle;
      endcase
      if (Restart) begin
         state_d = StIdle;
         cnt_d   = '0;
         step_d  = 1'b0;
         busy_d  = 1'b0;
         fault_d = 1'b0;
         pop     = 1'b0;
      end
   end

   // Pop first, then judge the candidate against the post-pop tail or Dir.
   always_comb begin
      count_pop = count_q - {1'b0, pop};
      head_pop  = pop ? q_q[1] : q_q[0];
      dir_pop   = pop ? q_q[0] : dir_q;
      ref_dir   = (count_pop == 2'd2) ? q_q[1] : (count_pop == 2'd1) ? head_pop : dir_pop;
      accept    = cand_vld && (count_pop != 2'd2) && (cand != ref_dir) &&
                  (cand != opposite(ref_dir));
      q_d[0]    = head_pop;
      q_d[1]    = q_q[1];
      count_d   = count_pop;
      dir_d     = dir_pop;
      if (accept) begin
         if (count_pop == 2'd0) q_d[0] = cand;
         else                   q_d[1] = cand;
         count_d = count_pop + 2'd1;
      end
      if (Restart) begin
         count_d = 2'd0;
         dir_d   = DirRight;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         period_q <= '0;
         step_q   <= 1'b0;
         busy_q   <= 1'b0;
         fault_q  <= 1'b0;
         dir_q    <= DirRight;
         q_q      <= '0;
         count_q  <= 2'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         step_q   <= step_d;
         busy_q   <= busy_d;
         fault_q  <= fault_d;
         dir_q    <= dir_d;
         q_q      <= q_d;
         count_q  <= count_d;
      end
   end

   assign core.Step = step_q;
   assign core.Dir  = dir_q;
   assign core.Busy = busy_q;
   assign Fault     = fault_q;
   assign Q_Count   = count_q;

endmodule

// File: tb/tb_snake_move_sched.sv
// Bench for snake_move_sched: directed scenarios with randomized lengths and
// button patterns, checked against a queue-based reference model.
module tb_snake_move_sched;
   import snake_pkg::*;

   localparam int Base = 20;
   localparam int Speed = 2;
   localparam int MinP = 8;
   localparam int Tout = 6;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       Left = 1'b0, Right = 1'b0, Up = 1'b0, Down = 1'b0;
   logic       Enable = 1'b0, Restart = 1'b0;
   logic [3:0] Length = 4'd0;
   logic       Fault;
   logic [1:0] Q_Count;

   int   n_checks = 0;
   int   n_errors = 0;
   dir_t mq[$];
   dir_t mdir = DirRight;

   snake_move_sched_if core_if ();

   always #5 Clk = ~Clk;

   snake_move_sched #(
      .CNT_W(26), .BASE_PERIOD(Base), .SPEEDUP(Speed), .MIN_PERIOD(MinP), .ACK_TIMEOUT(Tout)
   ) dut (
      .Clk(Clk), .Reset(Reset), .Left(Left), .Right(Right), .Up(Up), .Down(Down),
      .Enable(Enable), .Restart(Restart), .Length(Length), .core(core_if),
      .Fault(Fault), .Q_Count(Q_Count)
   );

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int ref_period(input int len);
      int p = Base - len * Speed;
      return (p < MinP) ? MinP : p;
   endfunction

   // Highest-priority pressed button wins; reversals, repeats and a full queue reject it.
   function automatic void model_push(input logic [3:0] m);
      dir_t prio[4] = '{DirLeft, DirRight, DirUp, DirDown};
      dir_t cand, refd;
      int   win = -1;
      for (int i = 0; i < 4; i++) if (win < 0 && m[i]) win = i;
      if (win < 0) return;
      cand = prio[win];
      refd = (mq.size() > 0) ? mq[$] : mdir;
      if (mq.size() < 2 && cand != refd && (cand ^ refd) != 2'b01) mq.push_back(cand);
   endfunction

   function automatic void model_pop();
      if (mq.size() > 0) mdir = mq.pop_front();
   endfunction

   task automatic press(input logic [3:0] m);
      {Down, Up, Right, Left} = m;
      cyc();
      {Down, Up, Right, Left} = 4'b0;
      cyc();
      check("q_before_edge", Q_Count, mq.size());
      cyc();
      model_push(m);
      check("q_after_edge", Q_Count, mq.size());
   endtask

   task automatic wait_step(output int n);
      n = 0;
      do begin
         cyc();
         n++;
      end while (core_if.Step !== 1'b1 && n < 100);
      check("step_seen", core_if.Step, 1);
   endtask

   task automatic issue_from_idle();
      int n;
      Enable = 1'b1;
      wait_step(n);
      check("latency_from_idle", n, ref_period(Length) + 1);
      model_pop();
      check("dir_at_step", core_if.Dir, mdir);
      check("busy_at_step", core_if.Busy, 1);
   endtask

   task automatic ack(input logic en);
      cyc();
      check("step_single", core_if.Step, 0);
      core_if.Step_Ack = 1'b1;
      Enable = en;
      cyc();
      core_if.Step_Ack = 1'b0;
      check("busy_cleared", core_if.Busy, 0);
      check("q_after_step", Q_Count, mq.size());
   endtask

   initial begin
      int         n, p, k;
      int         lens[4];
      logic       seen;
      logic [3:0] m;
      core_if.Step_Ack = 1'b0;

      cyc();
      check("rst_step", core_if.Step, 0);
      check("rst_dir", core_if.Dir, DirRight);
      check("rst_busy", core_if.Busy, 0);
      check("rst_fault", Fault, 0);
      check("rst_qcount", Q_Count, 0);
      Reset = 1'b0;

      // Pacing with a mix of lengths, including the saturated period
      Length = 4'd1;
      Enable = 1'b1;
      wait_step(n);
      check("first_tick", n, ref_period(1) + 1);
      check("dir_pace", core_if.Dir, DirRight);
      lens = '{15, 0, 0, 1};
      lens[1] = $urandom_range(0, 15);
      lens[2] = $urandom_range(0, 15);
      foreach (lens[i]) begin
         Length = 4'(lens[i]);
         ack(1'b1);
         wait_step(n);
         check("tick_spacing", n, ref_period(lens[i]));
         check("dir_pace", core_if.Dir, DirRight);
      end
      ack(1'b0);

      // Reversal and duplicate rejection, then two queued turns
      Length = 4'd4;
      press(4'b0001);
      check("reverse_rejected", Q_Count, 0);
      press(4'b0010);
      check("duplicate_rejected", Q_Count, 0);
      press(4'b0100);
      press(4'b0001);
      check("two_queued", Q_Count, 2);
      issue_from_idle();
      check("first_turn", core_if.Dir, DirUp);
      ack(1'b1);
      wait_step(n);
      check("queued_spacing", n, ref_period(4));
      model_pop();
      check("second_turn", core_if.Dir, DirLeft);
      ack(1'b0);

      // Arbitration, full queue, press landing in the ISSUE cycle
      press(4'b1100);
      check("arb_up_only", Q_Count, 1);
      press(4'b0010);
      press(4'b1000);
      check("full_drop", Q_Count, 2);
      m = ($urandom_range(0, 1) == 1) ? 4'b0100 : 4'b1000;
      Enable = 1'b1;
      p = ref_period(Length);
      repeat (p - 1) cyc();
      {Down, Up, Right, Left} = m;
      cyc();
      {Down, Up, Right, Left} = 4'b0;
      cyc();
      check("issue_step", core_if.Step, 1);
      model_pop();
      check("issue_dir", core_if.Dir, mdir);
      cyc();
      model_push(m);
      check("issue_press_accepted", Q_Count, mq.size());
      core_if.Step_Ack = 1'b1;
      Enable = 1'b0;
      cyc();
      core_if.Step_Ack = 1'b0;
      check("busy_cleared", core_if.Busy, 0);

      // Random button patterns interleaved with steps
      for (int i = 0; i < 8; i++) begin
         press(4'($urandom_range(0, 15)));
         if ($urandom_range(0, 1) == 1) begin
            Length = 4'($urandom_range(0, 15));
            issue_from_idle();
            ack(1'b0);
         end
      end

      // Acknowledge timeout
      issue_from_idle();
      for (int i = 1; i <= Tout; i++) begin
         cyc();
         check("fault_timing", Fault, 32'(i == Tout));
      end
      press(4'($urandom_range(1, 15)));
      seen = 1'b0;
      repeat (30) begin
         cyc();
         if (core_if.Step) seen = 1'b1;
      end
      check("no_step_in_fault", seen, 0);
      Restart = 1'b1;
      cyc();
      Restart = 1'b0;
      mq.delete();
      mdir = DirRight;
      check("restart_fault", Fault, 0);
      check("restart_dir", core_if.Dir, DirRight);
      check("restart_qcount", Q_Count, 0);
      check("restart_busy", core_if.Busy, 0);

      // Edge coinciding with Restart is dropped; counter restarts
      repeat (3) cyc();
      Up = 1'b1;
      cyc();
      Up = 1'b0;
      cyc();
      Restart = 1'b1;
      cyc();
      Restart = 1'b0;
      check("edge_dropped", Q_Count, 0);
      wait_step(n);
      check("restart_latency", n, ref_period(Length) + 1);
      check("restart_step_dir", core_if.Dir, DirRight);

      // Enable dropped mid-tick
      ack(1'b1);
      p = ref_period(Length);
      k = $urandom_range(1, p - 3);
      repeat (k) cyc();
      Enable = 1'b0;
      seen = 1'b0;
      repeat (2 * p) begin
         cyc();
         if (core_if.Step) seen = 1'b1;
      end
      check("no_step_disabled", seen, 0);
      issue_from_idle();
      ack(1'b0);

      // Asynchronous reset while waiting for the acknowledge
      press(4'b0100);
      press(4'b0001);
      issue_from_idle();
      cyc();
      check("busy_wait_ack", core_if.Busy, 1);
      #2 Reset = 1'b1;
      #1;
      check("areset_step", core_if.Step, 0);
      check("areset_busy", core_if.Busy, 0);
      check("areset_dir", core_if.Dir, DirRight);
      check("areset_qcount", Q_Count, 0);
      check("areset_fault", Fault, 0);
      cyc();
      Reset = 1'b0;
      cyc();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
